fetch_stage: RTL and testbench

- Instruction-fetch stage directly downstream of the program counter.
- Takes the current PC, issues one instruction-memory request at a time over a valid/ready handshake, and writes the returned instruction into the IF/ID pipeline register.
- Drives the PC's sequential-next input: PC+4 only in the cycle an instruction is committed to IF/ID, otherwise the current PC, so the PC holds while fetch is stalled.
- Branch redirect (flush) discards the in-flight fetch and any pending IF/ID contents.

---
 rtl/cpu_pkg.sv | 24 ++
 rtl/fetch_stage_if.sv | 34 +++
 rtl/if_id_reg.sv | 45 ++++
 rtl/fetch_stage.sv | 122 ++++++++++++
 tb/tb_fetch_stage.sv | 297 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions for the fetch stage and the pipeline registers.
// Contents:
//   XLEN, INSTR_W, INSTR_BYTES  - datapath widths and instruction size
//   fetch_state_t               - fetch sequencer states
//   add_instr_bytes()           - PC + INSTR_BYTES, wrapping modulo 2^XLEN
package cpu_pkg;

  localparam int XLEN        = 64;
  localparam int INSTR_W     = 32;
  localparam int INSTR_BYTES = 4;

  typedef enum logic [1:0] {
    REQ  = 2'd0,  // request presented to instruction memory
    WAIT = 2'd1,  // request accepted, waiting for the response
    HOLD = 2'd2,  // response parked because IF/ID was occupied
    DROP = 2'd3   // flushed while in flight, swallow the stale response
  } fetch_state_t;

  // The sum is truncated to XLEN bits, so the top of the address space wraps to 0.
  function automatic logic [XLEN-1:0] add_instr_bytes(input logic [XLEN-1:0] pc);
    return pc + XLEN'(INSTR_BYTES);
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response bus between the fetch stage and memory.
// Handshake rules:
//   Request: a transfer happens on a rising clk edge where imem_req_valid and
//   imem_req_ready are both high. Once valid is raised, it and imem_req_addr
//   stay stable until that transfer. Ready may change freely.
//   Response: imem_rsp_valid is a single-cycle pulse carrying imem_rsp_data.
//   It has no ready, because the fetch stage always takes the response.
// Modports: master = fetch stage, slave = instruction memory.
interface fetch_stage_if;
  import cpu_pkg::*;

  logic               imem_req_valid;
  logic               imem_req_ready;
  logic [XLEN-1:0]    imem_req_addr;
  logic               imem_rsp_valid;
  logic [INSTR_W-1:0] imem_rsp_data;

  modport master (
    output imem_req_valid,
    output imem_req_addr,
    input  imem_req_ready,
    input  imem_rsp_valid,
    input  imem_rsp_data
  );

  modport slave (
    input  imem_req_valid,
    input  imem_req_addr,
    output imem_req_ready,
    output imem_rsp_valid,
    output imem_rsp_data
  );

endinterface

// File: rtl/if_id_reg.sv
// Generic pipeline register holding valid, pc, pc_plus_4 and instr.
// Ports:
//   clk, reset          - clock and synchronous active-high reset (clears all fields)
//   load                - capture load_pc and load_instr and mark the register valid
//   consume             - the downstream stage took the contents, so clear valid
//   flush               - squash the contents. This has the highest priority after reset.
//   load_pc, load_instr - incoming data
//   valid, pc, pc_plus_4, instr - registered contents
// A load that happens in the same cycle as a consume wins, so the register refills
// without a bubble.
module if_id_reg
  import cpu_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic               consume,
  input  logic               flush,
  input  logic [XLEN-1:0]    load_pc,
  input  logic [INSTR_W-1:0] load_instr,
  output logic               valid,
  output logic [XLEN-1:0]    pc,
  output logic [XLEN-1:0]    pc_plus_4,
  output logic [INSTR_W-1:0] instr
);

  always_ff @(posedge clk) begin
    if (reset) begin
      valid     <= 1'b0;
      pc        <= '0;
      pc_plus_4 <= '0;
      instr     <= '0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (load) begin
      valid     <= 1'b1;
      pc        <= load_pc;
      pc_plus_4 <= add_instr_bytes(load_pc);
      instr     <= load_instr;
    end else if (consume) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage. It sits directly after the program counter.
// It issues one instruction-memory request at a time and places each returned
// instruction into the IF/ID register.
// Ports:
//   clk, reset     - clock and synchronous active-high reset
//   pc_in          - current PC
//   pc_seq_out     - sequential next PC. It is pc_in+4 only in a commit cycle; otherwise it is pc_in.
//   flush          - branch redirect. Drops the in-flight fetch and the IF/ID contents.
//   imem           - instruction-memory bus (master side)
//   id_ready       - decode takes the IF/ID contents this cycle
//   ifid_*         - IF/ID register outputs
//   state_dbg      - current sequencer state
module fetch_stage
  import cpu_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic [XLEN-1:0]    pc_in,
  output logic [XLEN-1:0]    pc_seq_out,
  input  logic               flush,
  fetch_stage_if.master      imem,
  input  logic               id_ready,
  output logic               ifid_valid,
  output logic [XLEN-1:0]    ifid_pc,
  output logic [XLEN-1:0]    ifid_pc_plus_4,
  output logic [INSTR_W-1:0] ifid_instr,
  output fetch_state_t       state_dbg
);

  fetch_state_t       state;
  logic [XLEN-1:0]    req_pc;
  logic [INSTR_W-1:0] hold_buf;
  logic               req_hs;
  logic               slot_free;
  logic               commit;
  logic [INSTR_W-1:0] commit_instr;

  assign imem.imem_req_valid = (state == REQ) && !reset;
  assign imem.imem_req_addr  = pc_in;
  assign req_hs              = imem.imem_req_valid && imem.imem_req_ready;
  assign slot_free           = !ifid_valid || id_ready;
  assign state_dbg           = state;

  // A commit writes IF/ID. It is also the only event that lets the PC advance.
  always_comb begin
    commit       = 1'b0;
    commit_instr = imem.imem_rsp_data;
    if (!reset && !flush) begin
      case (state)
        WAIT: commit = imem.imem_rsp_valid && slot_free;
        HOLD: begin
          commit       = slot_free;
          commit_instr = hold_buf;
        end
        default: commit = 1'b0;
      endcase
    end
  end

  assign pc_seq_out = commit ? add_instr_bytes(pc_in) : pc_in;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= REQ;
      req_pc   <= '0;
      hold_buf <= '0;
    end else if (flush) begin
      case (state)
        REQ: begin
          // A request accepted in the flush cycle is stale. Its response must be swallowed.
          if (req_hs) begin
            req_pc <= pc_in;
            state  <= DROP;
          end
        end
        WAIT:    state <= imem.imem_rsp_valid ? REQ : DROP;
        HOLD:    state <= REQ;
        // Keep waiting for the stale response. If it lands in this cycle, it is
        // already discarded, so resume fetching.
        DROP:    state <= imem.imem_rsp_valid ? REQ : DROP;
        default: state <= REQ;
      endcase
    end else begin
      case (state)
        REQ: begin
          if (req_hs) begin
            req_pc <= pc_in;
            state  <= WAIT;
          end
        end
        WAIT: begin
          if (imem.imem_rsp_valid) begin
            if (slot_free) begin
              state <= REQ;
            end else begin
              hold_buf <= imem.imem_rsp_data;
              state    <= HOLD;
            end
          end
        end
        HOLD:    if (slot_free) state <= REQ;
        DROP:    if (imem.imem_rsp_valid) state <= REQ;
        default: state <= REQ;
      endcase
    end
  end

  if_id_reg u_if_id_reg (
    .clk        (clk),
    .reset      (reset),
    .load       (commit),
    .consume    (id_ready),
    .flush      (flush),
    .load_pc    (req_pc),
    .load_instr (commit_instr),
    .valid      (ifid_valid),
    .pc         (ifid_pc),
    .pc_plus_4  (ifid_pc_plus_4),
    .instr      (ifid_instr)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed vectors, a transaction-level reference model
// checked every cycle, and hand-computed literal expectations.
module tb_fetch_stage;
  import cpu_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [XLEN-1:0]    pc_in = '0;
  logic [XLEN-1:0]    pc_seq_out;
  logic               flush = 1'b0;
  logic               id_ready = 1'b1;
  logic               ifid_valid;
  logic [XLEN-1:0]    ifid_pc;
  logic [XLEN-1:0]    ifid_pc_plus_4;
  logic [INSTR_W-1:0] ifid_instr;
  fetch_state_t       state_dbg;

  fetch_stage_if imem_bus();

  fetch_stage dut (
    .clk            (clk),
    .reset          (reset),
    .pc_in          (pc_in),
    .pc_seq_out     (pc_seq_out),
    .flush          (flush),
    .imem           (imem_bus),
    .id_ready       (id_ready),
    .ifid_valid     (ifid_valid),
    .ifid_pc        (ifid_pc),
    .ifid_pc_plus_4 (ifid_pc_plus_4),
    .ifid_instr     (ifid_instr),
    .state_dbg      (state_dbg)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Outstanding requests are held in a queue. Entries marked drop were killed by a flush.
  typedef struct { logic [63:0] pc; bit drop; } out_t;
  typedef struct { logic [63:0] pc; logic [31:0] instr; } held_t;
  out_t  out_q[$];
  held_t held_q[$];
  logic [63:0] exp_q[$];  // instructions expected to reach IF/ID, in order
  bit          m_valid = 1'b0;
  logic [63:0] m_pc = '0;
  logic [31:0] m_instr = '0;
  bit          m_zero = 1'b0;   // IF/ID fields must read zero (since reset, nothing committed)

  always @(negedge clk) begin
    bit          exp_rv;
    bit          slot_free;
    bit          commit;
    logic [63:0] c_pc;
    logic [31:0] c_instr;
    out_t        o;
    commit  = 1'b0;
    c_pc    = '0;
    c_instr = '0;
    exp_rv  = !reset && out_q.size() == 0 && held_q.size() == 0;
    chk("m_req_valid", imem_bus.imem_req_valid, exp_rv);
    if (exp_rv) chk("m_req_addr", imem_bus.imem_req_addr, pc_in);
    chk("m_ifid_valid", ifid_valid, m_valid);
    if (m_valid || m_zero) begin
      chk("m_ifid_pc", ifid_pc, m_pc);
      chk("m_ifid_pc_plus_4", ifid_pc_plus_4, m_zero ? 64'd0 : m_pc + 64'd4);
      chk("m_ifid_instr", ifid_instr, m_instr);
    end
    slot_free = !m_valid || id_ready;
    if (reset) begin
      chk("m_pc_seq_reset", pc_seq_out, pc_in);
      out_q.delete();
      held_q.delete();
      m_valid = 1'b0; m_pc = '0; m_instr = '0; m_zero = 1'b1;
    end else if (flush) begin
      if (imem_bus.imem_rsp_valid && out_q.size() > 0) o = out_q.pop_front();
      foreach (out_q[i]) out_q[i].drop = 1'b1;
      held_q.delete();
      if (exp_rv && imem_bus.imem_req_ready) out_q.push_back('{pc: pc_in, drop: 1'b1});
      m_valid = 1'b0;
    end else begin
      if (held_q.size() > 0) begin
        if (slot_free) begin
          commit = 1'b1; c_pc = held_q[0].pc; c_instr = held_q[0].instr;
          held_q.delete();
        end
      end else if (out_q.size() > 0 && imem_bus.imem_rsp_valid) begin
        o = out_q.pop_front();
        if (!o.drop) begin
          if (slot_free) begin
            commit = 1'b1; c_pc = o.pc; c_instr = imem_bus.imem_rsp_data;
          end else begin
            held_q.push_back('{pc: o.pc, instr: imem_bus.imem_rsp_data});
          end
        end
      end
      if (exp_rv && imem_bus.imem_req_ready) out_q.push_back('{pc: pc_in, drop: 1'b0});
      chk("m_pc_seq", pc_seq_out, commit ? pc_in + 64'd4 : pc_in);
      if (commit) begin
        m_valid = 1'b1; m_pc = c_pc; m_instr = c_instr; m_zero = 1'b0;
      end else if (id_ready) begin
        m_valid = 1'b0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic mid();
    @(negedge clk); #1;
  endtask

  task automatic drive_mem(input logic ready, input logic rsp, input logic [31:0] data);
    imem_bus.imem_req_ready = ready;
    imem_bus.imem_rsp_valid = rsp;
    imem_bus.imem_rsp_data  = data;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- directed stimulus ----------------
  initial begin
    drive_mem(1'b1, 1'b0, 32'h0);
    pc_in = 64'h20;
    step(); step();
    // Reset state
    mid();
    chk("rst_ifid_valid", ifid_valid, 1'b0);
    chk("rst_req_valid", imem_bus.imem_req_valid, 1'b0);
    chk("rst_pc_seq", pc_seq_out, 64'h20);
    chk("rst_ifid_instr", ifid_instr, 64'h0);
    step();

    // Basic fetch at PC 0
    reset = 1'b0; pc_in = 64'h0;
    mid();
    chk("basic_req_addr", imem_bus.imem_req_addr, 64'h0);
    step();
    drive_mem(1'b0, 1'b1, 32'h00500093);
    mid();
    chk("basic_pc_seq", pc_seq_out, 64'h4);
    step();

    // Request backpressure at 0x40
    drive_mem(1'b0, 1'b0, 32'h0);
    pc_in = 64'h40;
    mid();
    chk("basic_ifid_valid", ifid_valid, 1'b1);
    chk("basic_ifid_pc", ifid_pc, 64'h0);
    chk("basic_ifid_pc4", ifid_pc_plus_4, 64'h4);
    chk("basic_ifid_instr", ifid_instr, 64'h00500093);
    for (int i = 0; i < 3; i++) begin
      if (i > 0) mid();
      chk("bp_req_valid", imem_bus.imem_req_valid, 1'b1);
      chk("bp_req_addr", imem_bus.imem_req_addr, 64'h40);
      chk("bp_pc_seq", pc_seq_out, 64'h40);
      step();
    end
    imem_bus.imem_req_ready = 1'b1;
    mid();
    chk("bp_hs_valid", imem_bus.imem_req_valid, 1'b1);
    step();

    // Commit 0x40 into an empty slot, then stall decode
    drive_mem(1'b0, 1'b1, 32'h11111113);
    id_ready = 1'b0;
    mid();
    chk("bp_state_wait", state_dbg, WAIT);
    chk("c40_pc_seq", pc_seq_out, 64'h44);
    step();
    drive_mem(1'b1, 1'b0, 32'h0);
    pc_in = 64'h44;
    mid();
    chk("c40_ifid_instr", ifid_instr, 64'h11111113);
    step();
    drive_mem(1'b0, 1'b1, 32'hDEADBEEF);
    mid();
    chk("stall_pc_seq_wait", pc_seq_out, 64'h44);
    step();
    drive_mem(1'b0, 1'b0, 32'h0);
    mid();
    chk("stall_state_hold", state_dbg, HOLD);
    chk("stall_ifid_instr", ifid_instr, 64'h11111113);
    chk("stall_ifid_pc", ifid_pc, 64'h40);
    chk("stall_pc_seq_hold", pc_seq_out, 64'h44);
    step();
    id_ready = 1'b1;
    mid();
    chk("release_pc_seq", pc_seq_out, 64'h48);
    step();
    pc_in = 64'h48; id_ready = 1'b0;
    drive_mem(1'b1, 1'b0, 32'h0);
    mid();
    chk("release_ifid_instr", ifid_instr, 64'hDEADBEEF);
    chk("release_ifid_pc", ifid_pc, 64'h44);
    chk("release_ifid_pc4", ifid_pc_plus_4, 64'h48);
    step();

    // Flush in WAIT, response 2 cycles later
    drive_mem(1'b0, 1'b0, 32'h0);
    flush = 1'b1; pc_in = 64'h100;
    mid();
    step();
    flush = 1'b0;
    mid();
    chk("flw_state_drop", state_dbg, DROP);
    chk("flw_ifid_valid", ifid_valid, 1'b0);
    chk("flw_req_valid", imem_bus.imem_req_valid, 1'b0);
    chk("flw_pc_seq", pc_seq_out, 64'h100);
    step();
    drive_mem(1'b0, 1'b1, 32'hBAD00013);
    mid();
    chk("flw_drop_pc_seq", pc_seq_out, 64'h100);
    step();
    drive_mem(1'b1, 1'b0, 32'h0);
    mid();
    chk("flw_req_addr", imem_bus.imem_req_addr, 64'h100);
    chk("flw_ifid_valid2", ifid_valid, 1'b0);
    step();

    // Flush coincident with response
    drive_mem(1'b0, 1'b1, 32'h12345678);
    flush = 1'b1; pc_in = 64'h200;
    mid();
    step();
    flush = 1'b0;
    drive_mem(1'b0, 1'b0, 32'h0);
    mid();
    chk("flr_state_req", state_dbg, REQ);
    chk("flr_req_addr", imem_bus.imem_req_addr, 64'h200);
    chk("flr_ifid_valid", ifid_valid, 1'b0);
    step();

    // Wrap-around PC
    pc_in = 64'hFFFF_FFFF_FFFF_FFFC; id_ready = 1'b1;
    imem_bus.imem_req_ready = 1'b1;
    mid();
    step();
    drive_mem(1'b0, 1'b1, 32'h0000006F);
    mid();
    chk("wrap_pc_seq", pc_seq_out, 64'h0);
    step();
    drive_mem(1'b0, 1'b0, 32'h0);
    pc_in = 64'h0;
    mid();
    chk("wrap_ifid_pc", ifid_pc, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("wrap_ifid_pc4", ifid_pc_plus_4, 64'h0);
    chk("wrap_ifid_instr", ifid_instr, 64'h6F);
    step();

    // Reset while in WAIT, late response ignored
    imem_bus.imem_req_ready = 1'b1;
    mid();
    step();
    imem_bus.imem_req_ready = 1'b0;
    reset = 1'b1;
    mid();
    chk("rw_req_valid_rst", imem_bus.imem_req_valid, 1'b0);
    step();
    reset = 1'b0;
    drive_mem(1'b0, 1'b1, 32'hCAFEF00D);
    mid();
    chk("rw_state_req", state_dbg, REQ);
    chk("rw_req_valid", imem_bus.imem_req_valid, 1'b1);
    chk("rw_req_addr", imem_bus.imem_req_addr, 64'h0);
    chk("rw_ifid_valid", ifid_valid, 1'b0);
    chk("rw_pc_seq", pc_seq_out, 64'h0);
    step();
    drive_mem(1'b0, 1'b0, 32'h0);
    mid();
    chk("rw_ifid_valid2", ifid_valid, 1'b0);
    chk("rw_state_req2", state_dbg, REQ);
    step(); step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
